skinny_round_ctrl: RTL

Round sequencer for the SKINNY-128-384+ tweakable block cipher used by the Romulus core. It owns the state, key, tweak and counter registers and drives them into the combinational round datapath (`tweakablecipher`, `numrnd` rounds per cycle). It generates the 6-bit round constants and counts cycles until all rounds are done. It then holds the result under a valid/ready handshake for the mode-level control logic.

---
 rtl/skinny_round_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/skinny_round_ctrl.sv
// rtl/skinny_round_ctrl.sv - SKINNY-128-384+ round sequencer: owns state/key/tweak/counter registers,
// generates round constants and counts cycles until the block completes.
module skinny_round_ctrl #(
  parameter int numrnd   = 2,
  parameter int fullcnt  = 1,
  parameter int totalrnd = 40
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [127:0]                key_in,
  input  logic [127:0]                tweak_in,
  input  logic [127:0]                state_in,
  input  logic [64+64*fullcnt-1:0]    cnt_in,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [127:0]                state_out,
  output logic [127:0]                roundkey,
  output logic [127:0]                roundtweak,
  output logic [127:0]                roundstate,
  output logic [64+64*fullcnt-1:0]    roundcnt,
  output logic [6*numrnd-1:0]         constant,
  input  logic [127:0]                nextkey,
  input  logic [127:0]                nexttweak,
  input  logic [127:0]                nextstate,
  input  logic [64+64*fullcnt-1:0]    nextcnt
);

  localparam int CW   = 64 + 64 * fullcnt;
  localparam int NCYC = totalrnd / numrnd;
  localparam int IW   = $clog2(NCYC) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [127:0]    key_q, key_d;
  logic [127:0]    tweak_q, tweak_d;
  logic [127:0]    st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [5:0]      rc_q, rc_d;
  logic [IW-1:0]   rndidx_q, rndidx_d;
  logic [6*numrnd-1:0] rc_chain;
  logic [5:0]      rc_walk;

  function automatic logic [5:0] lfsr_step(input logic [5:0] x);
    return {x[4:0], x[5] ^ x[4] ^ 1'b1};
  endfunction

  // Slice i is the LFSR advanced i+1 steps from the current rc.
  always_comb begin
    rc_chain = '0;
    rc_walk  = rc_q;
    for (int i = 0; i < numrnd; i++) begin
      rc_walk = lfsr_step(rc_walk);
      rc_chain[6*i +: 6] = rc_walk;
    end
  end

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    tweak_d  = tweak_q;
    st_d     = st_q;
    cnt_d    = cnt_q;
    rc_d     = rc_q;
    rndidx_d = rndidx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d    = key_in;
          tweak_d  = tweak_in;
          st_d     = state_in;
          cnt_d    = cnt_in;
          rc_d     = 6'h00;
          rndidx_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        key_d    = nextkey;
        tweak_d  = nexttweak;
        st_d     = nextstate;
        cnt_d    = nextcnt;
        rc_d     = rc_chain[6*numrnd-1 -: 6];
        rndidx_d = rndidx_q + IW'(1);
        if (rndidx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      key_q    <= '0;
      tweak_q  <= '0;
      st_q     <= '0;
      cnt_q    <= '0;
      rc_q     <= '0;
      rndidx_q <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      tweak_q  <= tweak_d;
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      rc_q     <= rc_d;
      rndidx_q <= rndidx_d;
    end
  end

  // Constants are only meaningful while rounds are being captured.
  assign constant   = (state_q == RUN) ? rc_chain : '0;
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign state_out  = st_q;
  assign roundkey   = key_q;
  assign roundtweak = tweak_q;
  assign roundstate = st_q;
  assign roundcnt   = cnt_q;

endmodule
